mont_modexp_ctrl: RTL and testbench



---
 rtl/mont_modexp_ctrl.sv | 118 +++++++++++
 tb/tb_mont_modexp_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl: MSB-first square-and-multiply sequencer driving a Montgomery multiplier
module mont_modexp_ctrl #(
   parameter int EXP_W = 192
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [191:0]     base_m,
   input  logic [191:0]     one_m,
   input  logic [EXP_W-1:0] exp,
   output logic [191:0]     result,
   output logic             done,
   output logic             busy,
   output logic [191:0]     mm_x,
   output logic [191:0]     mm_y,
   output logic             mm_start,
   input  logic [191:0]     mm_z,
   input  logic             mm_done
);
   localparam int IW = EXP_W > 1 ? $clog2(EXP_W) : 1;
   typedef enum logic [2:0] {IDLE, SQ, MUL, WAIT, NEXT, FIN} state_t;
   state_t state_q, state_d;
   logic [191:0] acc_q, acc_d, base_q, base_d, result_q, result_d;
   logic [191:0] mm_x_q, mm_x_d, mm_y_q, mm_y_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [IW-1:0] idx_q, idx_d;
   logic op_q, op_d, seen_lo_q, seen_lo_d, done_q, done_d, busy_q, busy_d, mm_start_q, mm_start_d;
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      base_d = base_q;
      exp_d = exp_q;
      idx_d = idx_q;
      op_d = op_q;
      seen_lo_d = seen_lo_q;
      result_d = result_q;
      busy_d = busy_q;
      mm_x_d = mm_x_q;
      mm_y_d = mm_y_q;
      done_d = 1'b0;
      mm_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = start;
            if (start) begin
               acc_d = one_m;
               base_d = base_m;
               exp_d = exp;
               idx_d = IW'(EXP_W - 1);
               state_d = SQ;
            end
         end
         SQ, MUL: begin
            mm_x_d = acc_q;
            mm_y_d = state_q == MUL ? base_q : acc_q;
            mm_start_d = 1'b1;
            op_d = state_q == MUL;
            seen_lo_d = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            // a done level still high from the previous op is ignored until it has dropped once
            if (!mm_done) seen_lo_d = 1'b1;
            if (seen_lo_q && mm_done) begin
               acc_d = mm_z;
               state_d = (!op_q && exp_q[idx_q]) ? MUL : NEXT;
            end
         end
         NEXT: begin
            state_d = idx_q == '0 ? FIN : SQ;
            if (idx_q != '0) idx_d = idx_q - 1'b1;
         end
         FIN: begin
            result_d = acc_q;
            done_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q <= '0;
         base_q <= '0;
         exp_q <= '0;
         idx_q <= '0;
         op_q <= 1'b0;
         seen_lo_q <= 1'b0;
         result_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         mm_x_q <= '0;
         mm_y_q <= '0;
         mm_start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         base_q <= base_d;
         exp_q <= exp_d;
         idx_q <= idx_d;
         op_q <= op_d;
         seen_lo_q <= seen_lo_d;
         result_q <= result_d;
         done_q <= done_d;
         busy_q <= busy_d;
         mm_x_q <= mm_x_d;
         mm_y_q <= mm_y_d;
         mm_start_q <= mm_start_d;
      end
   end
   assign result = result_q;
   assign done = done_q;
   assign busy = busy_q;
   assign mm_x = mm_x_q;
   assign mm_y = mm_y_q;
   assign mm_start = mm_start_q;
endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// tb_mont_modexp_ctrl: scoreboard bench with a mod-13 multiplier model shared by an 8-bit and a 192-bit controller
module tb_mont_modexp_ctrl;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, sel = 1'b0, level = 1'b0;
   logic [191:0] base_m = '0, one_m = '0, exp192 = '0;
   logic [7:0] exp8 = '0;
   logic [191:0] result0, result1, x0, x1, y0, y1, mm_z, res, mx, my;
   logic done0, done1, busy0, busy1, ms0, ms1, mm_done, done, busy, ms, start0, start1;
   int cnt, tests, fails, ops, lat;
   typedef struct {logic [191:0] res; int ops; int lat;} exp_t;
   exp_t q[$];
   exp_t e;
   always #5 clk = ~clk;
   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign res = sel ? result1 : result0;
   assign done = sel ? done1 : done0;
   assign busy = sel ? busy1 : busy0;
   assign ms = sel ? ms1 : ms0;
   assign mx = sel ? x1 : x0;
   assign my = sel ? y1 : y0;
   mont_modexp_ctrl #(.EXP_W(8)) u0 (.clk(clk), .reset(reset), .start(start0), .base_m(base_m), .one_m(one_m),
      .exp(exp8), .result(result0), .done(done0), .busy(busy0), .mm_x(x0), .mm_y(y0), .mm_start(ms0),
      .mm_z(mm_z), .mm_done(mm_done));
   mont_modexp_ctrl #(.EXP_W(192)) u1 (.clk(clk), .reset(reset), .start(start1), .base_m(base_m), .one_m(one_m),
      .exp(exp192), .result(result1), .done(done1), .busy(busy1), .mm_x(x1), .mm_y(y1), .mm_start(ms1),
      .mm_z(mm_z), .mm_done(mm_done));
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 0;
         mm_done <= 1'b0;
         mm_z <= '0;
      end else if (ms) begin
         cnt <= 5;
         mm_done <= 1'b0;
         mm_z <= ((mx % 13) * (my % 13)) % 13;
      end else begin
         if (cnt > 0) cnt <= cnt - 1;
         mm_done <= (cnt == 1) || (level && mm_done);
      end
   end
   task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
   always @(negedge clk) begin
      if (reset) begin
         ops = 0;
         lat = 0;
      end else begin
         if (ms) ops++;
         if (done) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_done: got a done pulse, expected none");
            end else begin
               e = q.pop_front();
               chk("result", res, e.res);
               chk("mm_ops", 192'(ops), 192'(e.ops));
               chk("latency", 192'(lat + 1), 192'(e.lat));
               chk("busy_at_done", 192'(busy), 192'(1));
            end
            ops = 0;
            lat = 0;
         end else if (busy) lat++;
      end
   end
   task automatic go(input logic [191:0] b, o, ex, want, input int nops, ew, input bit push);
      @(negedge clk);
      base_m = b;
      one_m = o;
      exp8 = ex[7:0];
      exp192 = ex;
      if (push) q.push_back('{want, nops, 2 + nops * 8 + ew});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base_m = 192'($urandom);
      one_m = 192'($urandom);
      exp8 = 8'($urandom);
      exp192 = 192'($urandom);
   endtask
   task automatic wait_done(input int max);
      int n = 0;
      while (!done && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no done within %0d cycles, expected done", max);
      end
   endtask
   initial begin
      int seen, n;
      repeat (3) @(negedge clk);
      chk("rst_result", res, 0);
      chk("rst_done", 192'(done), 0);
      chk("rst_busy", 192'(busy), 0);
      chk("rst_mm_x", mx, 0);
      chk("rst_mm_y", my, 0);
      chk("rst_mm_start", 192'(ms), 0);
      reset = 1'b0;
      go(2, 1, 8'h05, 6, 10, 8, 1);
      wait_done(400);
      go(7, 1, 0, 1, 8, 8, 1);
      wait_done(400);
      level = 1'b1;
      go(3, 1, 8'hFF, 1, 16, 8, 1);
      wait_done(400);
      level = 1'b0;
      go(2, 1, 8'h05, 6, 10, 8, 1);
      repeat (20) @(negedge clk);
      base_m = 4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(400);
      base_m = 5;
      one_m = 1;
      exp8 = 8'h03;
      q.push_back('{192'd8, 10, 2 + 10 * 8 + 8});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", 192'(busy), 1);
      wait_done(400);
      go(2, 1, 8'h05, 6, 10, 8, 0);
      seen = 0;
      n = 0;
      while (seen < 3 && n < 400) begin
         @(negedge clk);
         n++;
         if (ms) seen++;
      end
      chk("pre_abort_busy", 192'(busy), 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_result", res, 0);
      chk("abort_done", 192'(done), 0);
      chk("abort_busy", 192'(busy), 0);
      chk("abort_mm_x", mx, 0);
      chk("abort_mm_y", my, 0);
      chk("abort_mm_start", 192'(ms), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      go(5, 1, 8'h03, 8, 10, 8, 1);
      wait_done(400);
      @(negedge clk);
      sel = 1'b1;
      // 2^(2^191) mod 13: 2^191 = 8 mod 12, and 2^8 = 256 = 9 mod 13
      go(2, 1, {1'b1, 191'b0}, 9, 193, 192, 1);
      wait_done(3000);
      @(negedge clk);
      chk("queue_drained", 192'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
